button_debouncer: RTL and testbench

- Input-side counterpart of the board LED drivers.
- Samples the board's active-low pushbuttons, synchronises them to clk, and debounces each one independently.
- Presents a clean pressed level plus single-cycle press, release and long-press event pulses to user logic (counters, mode selects, LED pattern controllers).
- Sits directly behind the top-level button pins; one instance serves all buttons.

---
 rtl/button_debouncer.sv | 173 +++++++++++++++++
 tb/tb_button_debouncer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer
//
// Samples active-low board pushbuttons, synchronises them to clk and
// debounces each button independently. For each button it provides a clean
// active-high pressed level plus single-cycle press, release and long-press
// pulses.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btn_n       raw button pins, active-low, asynchronous to clk
//   btn_level   debounced state, 1 = pressed
//   btn_press   1-cycle pulse when a press is accepted
//   btn_release 1-cycle pulse when a release is accepted
//   btn_long    1-cycle pulse when a press has lasted LONG_PRESS_CYCLES
//
// Handshake: there is none. Inputs are free-running levels. Outputs are
// registered levels and pulses with no back-pressure.
module button_debouncer #(
  parameter int NUM_BTN           = 2,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  // A zero long-press setting would give a zero-width counter, so keep one bit.
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = (LONG_PRESS_CYCLES > 0) ? HOLD_W'(LONG_PRESS_CYCLES) : '1;
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam bit                LONG_EN   = (LONG_PRESS_CYCLES != 0);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Two-flop synchroniser; resets to the released (high) pin level.
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] raw_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign raw_pressed = ~sync2;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    state_t            state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      case (state_q)
        RELEASED: begin
          if (raw_pressed[i]) begin
            state_d = DEB_PRESS;
            deb_d   = DEB_ONE;
          end
        end
        DEB_PRESS: begin
          if (!raw_pressed[i]) begin
            state_d = RELEASED;
            deb_d   = '0;
          end else if (deb_q == DEB_MAX) begin
            state_d     = PRESSED;
            level_d     = 1'b1;
            press_d     = 1'b1;
            hold_d      = '0;
            long_done_d = 1'b0;
          end else begin
            deb_d = deb_q + DEB_ONE;
          end
        end
        PRESSED: begin
          // The hold count advances on every PRESSED cycle, including the one
          // that leaves for DEB_RELEASE; only DEB_RELEASE cycles are frozen.
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
          end
          if (LONG_EN && !long_done_q && (hold_q == HOLD_FIRE)) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
          if (!raw_pressed[i]) begin
            state_d = DEB_RELEASE;
            deb_d   = DEB_ONE;
          end
        end
        DEB_RELEASE: begin
          // A bounce back to pressed resumes the hold count and keeps
          // long_done, so a long-press never fires twice for one press.
          if (raw_pressed[i]) begin
            state_d = PRESSED;
          end else if (deb_q == DEB_MAX) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
            deb_d     = '0;
          end else begin
            deb_d = deb_q + DEB_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
          deb_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= RELEASED;
        deb_q       <= '0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        deb_q       <= deb_d;
        hold_q      <= hold_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed testbench for button_debouncer with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20, NUM_BTN=2. Expected cycle positions are
// hand-computed: a pin level first sampled at edge T is accepted at T+6.
module tb_button_debouncer;

  localparam int NUM_BTN = 2;
  localparam int DEB     = 4;
  localparam int LONG    = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_BTN-1:0] btn_n = 2'b11;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_long;

  int n_checks = 0;
  int n_errors = 0;

  // Sticky OR of pulses seen since the last clear_seen().
  logic [NUM_BTN-1:0] seen_press;
  logic [NUM_BTN-1:0] seen_release;
  logic [NUM_BTN-1:0] seen_long;

  button_debouncer #(
    .NUM_BTN          (NUM_BTN),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    seen_press   = '0;
    seen_release = '0;
    seen_long    = '0;
  endtask

  // Advance one clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    seen_press   = seen_press | btn_press;
    seen_release = seen_release | btn_release;
    seen_long    = seen_long | btn_long;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive(input logic [NUM_BTN-1:0] v);
    btn_n = v;
  endtask

  initial begin
    clear_seen();
    // Reset
    ticks(3);
    check_eq("reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 8'h00);
    rst_n = 1'b1;
    ticks(3);

    // Clean press on button 0
    drive(2'b10);
    clear_seen();
    ticks(6);                                   // edges T..T+5
    check_eq("clean_no_early_press", seen_press, 2'b00);
    check_eq("clean_level_early", btn_level, 2'b00);
    tick();                                     // T+6
    check_eq("clean_press_pulse", btn_press, 2'b01);
    check_eq("clean_level_set", btn_level, 2'b01);
    check_eq("clean_no_release", btn_release, 2'b00);
    tick();                                     // T+7
    check_eq("clean_press_one_cycle", btn_press, 2'b00);
    check_eq("clean_level_hold", btn_level, 2'b01);
    drive(2'b11);
    clear_seen();
    ticks(6);                                   // R..R+5
    check_eq("clean_no_early_release", seen_release, 2'b00);
    check_eq("clean_level_in_deb_release", btn_level, 2'b01);
    tick();                                     // R+6
    check_eq("clean_release_pulse", btn_release, 2'b01);
    check_eq("clean_level_clear", btn_level, 2'b00);
    tick();
    check_eq("clean_release_one_cycle", btn_release, 2'b00);
    check_eq("clean_no_long", seen_long, 2'b00);

    // Bounce rejection
    clear_seen();
    drive(2'b10); ticks(3);
    drive(2'b11); tick();
    drive(2'b10); ticks(3);
    drive(2'b11); ticks(10);
    check_eq("bounce_no_press", seen_press, 2'b00);
    check_eq("bounce_level_low", btn_level, 2'b00);
    drive(2'b10);
    clear_seen();
    ticks(6);
    check_eq("bounce_no_early_press", seen_press, 2'b00);
    tick();
    check_eq("bounce_then_press", btn_press, 2'b01);
    ticks(3);                                   // pin low for 10 sampled edges
    drive(2'b11);
    clear_seen();
    ticks(10);
    check_eq("bounce_release_seen", seen_release, 2'b01);
    check_eq("bounce_level_after", btn_level, 2'b00);

    // Long press
    drive(2'b10);
    clear_seen();
    ticks(7);                                   // T+6
    check_eq("long_press_pulse", btn_press, 2'b01);
    clear_seen();
    ticks(19);                                  // T+25
    check_eq("long_not_early", seen_long, 2'b00);
    tick();                                     // T+26
    check_eq("long_pulse", btn_long, 2'b01);
    clear_seen();
    ticks(13);                                  // T+39
    check_eq("long_single", seen_long, 2'b00);
    drive(2'b11);
    ticks(6);
    check_eq("long_level_before_release", btn_level, 2'b01);
    tick();                                     // R+6
    check_eq("long_release_pulse", btn_release, 2'b01);
    check_eq("long_level_clear", btn_level, 2'b00);

    // Release bounce delays long-press by the frozen cycles
    drive(2'b10);
    clear_seen();
    ticks(7);                                   // T+6
    check_eq("glitch_press_pulse", btn_press, 2'b01);
    ticks(7);                                   // T+13
    drive(2'b11);
    ticks(2);                                   // high sampled at T+14, T+15
    drive(2'b10);
    clear_seen();
    ticks(12);                                  // T+27
    check_eq("glitch_long_not_early", seen_long, 2'b00);
    check_eq("glitch_no_release", seen_release, 2'b00);
    check_eq("glitch_level_held", btn_level, 2'b01);
    tick();                                     // T+28
    check_eq("glitch_long_delayed", btn_long, 2'b01);
    drive(2'b11);
    ticks(10);
    check_eq("glitch_level_after", btn_level, 2'b00);

    // Simultaneous press, independent release
    drive(2'b00);
    clear_seen();
    ticks(7);
    check_eq("simul_press", btn_press, 2'b11);
    check_eq("simul_level", btn_level, 2'b11);
    tick();
    drive(2'b10);
    clear_seen();
    ticks(7);
    check_eq("simul_release_one", btn_release, 2'b10);
    check_eq("simul_level_one", btn_level, 2'b01);

    // Reset mid-press with button 0 still held
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_clear", {btn_level, btn_press, btn_release, btn_long}, 8'h00);
    ticks(2);
    rst_n = 1'b1;
    clear_seen();
    ticks(6);                                   // E..E+5
    check_eq("rst_no_early_press", seen_press, 2'b00);
    tick();                                     // E+6
    check_eq("rst_repress", btn_press, 2'b01);
    check_eq("rst_level", btn_level, 2'b01);
    check_eq("rst_no_release", seen_release, 2'b00);

    drive(2'b11);
    ticks(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
